// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer owning the HI/LO registers.
// A shift-add multiplier or restoring divider runs for WIDTH iterations (RUN),
// then FIX applies sign correction and commits HI/LO with a one-cycle done.
//
// Optional build macro: MULDIV_EARLYOUT_EN (multiply leaves RUN as soon as the
// remaining multiplier bits are all zero; divide timing is unaffected).
//
// Ports:
//   clk      single clock, rising edge
//   reset    synchronous, active-high
//   startE   mul/div valid in Execute
//   opE      00 mult, 01 multu, 10 div, 11 divu
//   srcaE    multiplicand / dividend
//   srcbE    multiplier / divisor
//   mfreqD   mfhi/mflo in Decode
//   mdreqD   mul/div in Decode
//   stallD   stall request to the hazard unit
//   busy     operation in progress
//   done     one-cycle pulse, HI/LO just updated
//   divzero  last divide had a zero divisor (only while done=1)
//   hi, lo   HI and LO registers
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mfreqD,
    input  logic             mdreqD,
    output logic             stallD,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic              isDiv;
    logic              negRes;   // operand signs differ (signed ops only)
    logic              negRem;   // dividend negative (signed ops only)
    logic              divZ;
    logic [WIDTH-1:0]  origA;
    logic [DW-1:0]     acc;
    logic [DW-1:0]     mcand;
    logic [WIDTH-1:0]  opB;      // multiplier (shifts right) or divisor (fixed)
    logic [WIDTH-1:0]  quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH:0]    rem;

    logic              startSigned;
    logic [WIDTH-1:0]  absA;
    logic [WIDTH-1:0]  absB;
    logic [WIDTH:0]    divShift;
    logic [WIDTH:0]    divNext;
    logic              divGeq;
    logic              lastIter;
    logic [DW-1:0]     product;
    logic [WIDTH-1:0]  quoFix;
    logic [WIDTH-1:0]  remFix;

    // Operand conditioning, one restoring-divide step, end-of-RUN and sign fixes.
    always_comb begin
        startSigned = ~opE[0];
        absA = (startSigned && srcaE[WIDTH-1]) ? (WIDTH'(0) - srcaE) : srcaE;
        absB = (startSigned && srcbE[WIDTH-1]) ? (WIDTH'(0) - srcbE) : srcbE;

        divShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        divGeq   = (divShift >= {1'b0, opB});
        divNext  = divGeq ? (divShift - {1'b0, opB}) : divShift;

`ifdef MULDIV_EARLYOUT_EN
        // Stop once no set multiplier bits remain beyond the one consumed now.
        lastIter = (cnt == CNTW'(WIDTH - 1)) ||
                   (!isDiv && (opB[WIDTH-1:1] == '0));
`else
        lastIter = (cnt == CNTW'(WIDTH - 1));
`endif

        product = negRes ? (DW'(0) - acc) : acc;
        quoFix  = negRes ? (WIDTH'(0) - quo) : quo;
        remFix  = negRem ? (WIDTH'(0) - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZ    <= 1'b0;
            origA   <= '0;
            acc     <= '0;
            mcand   <= '0;
            opB     <= '0;
            quo     <= '0;
            rem     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (startE) begin
                        isDiv  <= opE[1];
                        negRes <= startSigned & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        negRem <= startSigned & srcaE[WIDTH-1];
                        divZ   <= opE[1] & (srcbE == '0);
                        origA  <= srcaE;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, absA};
                        opB    <= absB;
                        quo    <= absA;
                        rem    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        rem <= divNext;
                        quo <= {quo[WIDTH-2:0], divGeq};
                    end else begin
                        if (opB[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= {mcand[DW-2:0], 1'b0};
                        opB   <= {1'b0, opB[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNTW'(1);
                    if (lastIter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        if (divZ) begin
                            lo      <= '1;
                            hi      <= origA;
                            divzero <= 1'b1;
                        end else begin
                            lo <= quoFix;
                            hi <= remFix;
                        end
                    end else begin
                        {hi, lo} <= product;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign stallD = (busy | startE) & (mfreqD | mdreqD);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level behavioural model with
// plain-arithmetic results, per-cycle output compare, directed and random ops.
module tb_muldiv_seq;

    localparam int unsigned W = 32;
`ifdef MULDIV_EARLYOUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          startE;
    logic [1:0]    opE;
    logic [W-1:0]  srcaE;
    logic [W-1:0]  srcbE;
    logic          mfreqD;
    logic          mdreqD;
    logic          stallD;
    logic          busy;
    logic          done;
    logic          divzero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .mfreqD(mfreqD), .mdreqD(mdreqD),
        .stallD(stallD), .busy(busy), .done(done), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Architectural result {divzero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] calcRes(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                q = sa * sb;
                return {1'b0, 64'(q)};
            end
            2'b01: begin
                u = {32'd0, a} * {32'd0, b};
                return {1'b0, u};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Edges from the accepting edge to the commit edge.
    function automatic int calcLat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (!op[0] && b[31]) ? (32'd0 - b) : b;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return (op[1] || !EarlyOut) ? 33 : k + 1;
    endfunction

    logic [64:0] cRes;
    int          cLat;
    always_comb begin
        cRes = calcRes(opE, srcaE, srcbE);
        cLat = calcLat(opE, srcbE);
    end

    // Reference model: an accepted op counts down its latency, then commits.
    logic        mBusy, mDone, mDivz, pDz;
    logic [31:0] mHi, mLo, pHi, pLo;
    int          mRem;
    always @(posedge clk) begin
        if (reset) begin
            mBusy <= 1'b0; mDone <= 1'b0; mDivz <= 1'b0;
            mHi <= '0; mLo <= '0; mRem <= 0;
        end else if (mBusy) begin
            if (mRem == 1) begin
                mBusy <= 1'b0; mDone <= 1'b1; mDivz <= pDz;
                mHi <= pHi; mLo <= pLo; mRem <= 0;
            end else begin
                mRem <= mRem - 1; mDone <= 1'b0; mDivz <= 1'b0;
            end
        end else begin
            mDone <= 1'b0; mDivz <= 1'b0;
            if (startE) begin
                pDz <= cRes[64]; pHi <= cRes[63:32]; pLo <= cRes[31:0];
                mRem <= cLat; mBusy <= 1'b1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            check("busy", 64'(busy), 64'(mBusy));
            check("done", 64'(done), 64'(mDone));
            check("divzero", 64'(divzero), 64'(mDivz));
            check("hi", 64'(hi), 64'(mHi));
            check("lo", 64'(lo), 64'(mLo));
            check("stallD", 64'(stallD), 64'((mBusy | startE) & (mfreqD | mdreqD)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        opE = op; srcaE = a; srcbE = b; startE = 1'b1;
        #1;
        check("stall_issue", 64'(stallD), 64'(mfreqD | mdreqD));
        tick();
        startE = 1'b0;
    endtask

    task automatic waitDone(output int edges, output int busyCnt);
        edges = 0;
        busyCnt = int'(busy);
        for (int i = 0; i < 100; i++) begin
            tick();
            edges++;
            if (done) return;
            busyCnt += int'(busy);
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz, input int expLat);
        int e, bc;
        issue(op, a, b);
        waitDone(e, bc);
        check({name, "_hi"}, 64'(hi), 64'(expHi));
        check({name, "_lo"}, 64'(lo), 64'(expLo));
        check({name, "_divzero"}, 64'(divzero), 64'(expDz));
        check({name, "_model_hi"}, 64'(mHi), 64'(expHi));
        check({name, "_model_lo"}, 64'(mLo), 64'(expLo));
        check({name, "_latency"}, 64'(e), 64'(expLat));
        check({name, "_busy_cycles"}, 64'(bc), 64'(expLat));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, bc, lat;
        reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        mfreqD = 1'b0; mdreqD = 1'b0;
        tick();
        tick();
        checkOn = 1'b1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stallD), 64'd0);
        reset = 1'b0;
        tick();

        // mult -3 x 7 with an mfhi waiting in Decode the whole time.
        mfreqD = 1'b1;
        runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EarlyOut ? 4 : 33);
        check("stall_done_cycle", 64'(stallD), 64'd0);
        mfreqD = 1'b0;

        runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        runOp("mult_5x3", 2'b00, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, EarlyOut ? 3 : 33);
        runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
        runOp("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 33);
        tick();
        check("divzero_after", 64'(divzero), 64'd0);

        // A start while busy must be ignored.
        issue(2'b00, 32'd6, 32'd7);
        repeat (5) tick();
        opE = 2'b10; srcaE = 32'd1; srcbE = 32'd1; startE = 1'b1;
        tick();
        startE = 1'b0;
        waitDone(e, bc);
        check("ignore_hi", 64'(hi), 64'd0);
        check("ignore_lo", 64'(lo), 64'd42);

        // Reset at E10 aborts the op and clears HI/LO.
        tick();
        issue(2'b00, 32'd123, 32'd456);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        runOp("mult_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, EarlyOut ? 3 : 33);

        // Random ops, sometimes issued back-to-back in the done cycle.
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            mfreqD = 1'($urandom_range(0, 1));
            mdreqD = 1'($urandom_range(0, 1));
            lat = calcLat(op, b);
            issue(op, a, b);
            waitDone(e, bc);
            check("rnd_latency", 64'(e), 64'(lat));
            if ($urandom_range(0, 1) == 0) begin
                mfreqD = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        mfreqD = 1'b0;
        mdreqD = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
